multicore_mem_sync: RTL and testbench

//  Parametrised N-core front end for a single shared RAM port: round-robin arbitration
//  of core memory requests, address-triggered barrier synchronisation and aggregate completion.

---
 rtl/multicore_mem_sync.sv | 168 ++++++++++++++++
 tb/tb_multicore_mem_sync.sv | 424 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicore_mem_sync.sv
// multicore_mem_sync: lets NUM_CORES cores share one single-port synchronous RAM.
// Requests are arbitrated round-robin. An access to BARRIER_ADDR parks the
// issuing core until every core has either arrived at the barrier or finished.
// finish_process rises once all cores have reported done.
module multicore_mem_sync #(
  parameter int                NUM_CORES    = 3,
  parameter int                ADDR_W       = 16,
  parameter int                DATA_W       = 16,
  parameter logic [ADDR_W-1:0] BARRIER_ADDR = ADDR_W'(23)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [NUM_CORES-1:0]          core_req,
  input  logic [NUM_CORES-1:0]          core_we,
  input  logic [NUM_CORES*ADDR_W-1:0]   core_addr,
  input  logic [NUM_CORES*DATA_W-1:0]   core_wdata,
  input  logic [NUM_CORES-1:0]          core_finish,
  output logic [NUM_CORES-1:0]          core_gnt,
  output logic [NUM_CORES-1:0]          core_run,
  output logic [NUM_CORES-1:0]          core_rvalid,
  output logic [DATA_W-1:0]             core_rdata,
  output logic                          ram_read,
  output logic                          ram_write,
  output logic [ADDR_W-1:0]             ram_addr,
  output logic [DATA_W-1:0]             ram_wdata,
  input  logic [DATA_W-1:0]             ram_rdata,
  output logic                          finish_process
);
  localparam int PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam logic [NUM_CORES-1:0] ALL_ONES = '1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e               state_q;
  logic [NUM_CORES-1:0] run_q, run_d;
  logic [NUM_CORES-1:0] done_q, done_d;
  logic [NUM_CORES-1:0] arrived_q, arrived_d;
  logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic                 finish_q;

  logic [NUM_CORES-1:0] eligible, gnt;
  logic                 gnt_any, g_we;
  logic [PTR_W-1:0]     gnt_idx;
  logic [ADDR_W-1:0]    g_addr;
  logic [DATA_W-1:0]    g_wdata;

  // Memory pipeline: stage 1 drives the RAM, stage 2 tags the returning read.
  logic                 ram_read_q, ram_write_q;
  logic [ADDR_W-1:0]    ram_addr_q;
  logic [DATA_W-1:0]    ram_wdata_q;
  logic [NUM_CORES-1:0] rd_oh_q, rvalid_q;

  // Round-robin pick: first eligible core at or after rr_ptr, wrapping around.
  always_comb begin
    int sum;
    sum      = 0;
    eligible = (state_q == S_RUN) ? (core_req & run_q & ~done_q) : '0;
    gnt      = '0;
    gnt_any  = 1'b0;
    gnt_idx  = '0;
    g_we     = 1'b0;
    g_addr   = '0;
    g_wdata  = '0;
    for (int off = 0; off < NUM_CORES; off++) begin
      sum = int'(rr_ptr_q) + off;
      if (sum >= NUM_CORES) sum = sum - NUM_CORES;
      if (!gnt_any && eligible[sum]) begin
        gnt_any  = 1'b1;
        gnt_idx  = PTR_W'(sum);
        gnt[sum] = 1'b1;
        g_we     = core_we[sum];
        g_addr   = core_addr[sum*ADDR_W +: ADDR_W];
        g_wdata  = core_wdata[sum*DATA_W +: DATA_W];
      end
    end
  end

  // Next pointer, barrier parking/release and done tracking while running.
  always_comb begin
    if (gnt_any)
      rr_ptr_d = (gnt_idx == PTR_W'(NUM_CORES - 1)) ? '0 : gnt_idx + 1'b1;
    else
      rr_ptr_d = rr_ptr_q;

    done_d    = done_q | core_finish;
    run_d     = run_q;
    arrived_d = arrived_q;

    // The barrier access itself still goes to RAM; only the core is parked.
    if (gnt_any && (g_addr == BARRIER_ADDR)) begin
      run_d[gnt_idx]     = 1'b0;
      arrived_d[gnt_idx] = 1'b1;
    end

    // Finished cores stand in for arrivals so the rest are never stranded.
    if ((arrived_q | done_q) == ALL_ONES) begin
      run_d     = ~done_d;
      arrived_d = '0;
    end

    run_d = run_d & ~done_d;
  end

  // Control FSM with registered run/done/arrived masks and completion flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      run_q     <= '0;
      done_q    <= '0;
      arrived_q <= '0;
      rr_ptr_q  <= '0;
      finish_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_RUN;
            run_q   <= ALL_ONES;
          end
        end
        S_RUN: begin
          run_q     <= run_d;
          done_q    <= done_d;
          arrived_q <= arrived_d;
          rr_ptr_q  <= rr_ptr_d;
          if (done_q == ALL_ONES) begin
            state_q  <= S_DONE;
            finish_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // RAM strobes one cycle after grant, read-valid one cycle after the strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ram_read_q  <= 1'b0;
      ram_write_q <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      rd_oh_q     <= '0;
      rvalid_q    <= '0;
    end else begin
      ram_read_q  <= gnt_any & ~g_we;
      ram_write_q <= gnt_any & g_we;
      if (gnt_any) begin
        ram_addr_q  <= g_addr;
        ram_wdata_q <= g_wdata;
      end
      rd_oh_q  <= (gnt_any && !g_we) ? gnt : '0;
      rvalid_q <= rd_oh_q;
    end
  end

  assign core_gnt       = gnt;
  assign core_run       = run_q;
  assign core_rvalid    = rvalid_q;
  assign core_rdata     = (|rvalid_q) ? ram_rdata : '0;
  assign ram_read       = ram_read_q;
  assign ram_write      = ram_write_q;
  assign ram_addr       = ram_addr_q;
  assign ram_wdata      = ram_wdata_q;
  assign finish_process = finish_q;

endmodule

// File: tb/tb_multicore_mem_sync.sv
// Bench for multicore_mem_sync: directed scenarios plus a randomized run checked
// against a transaction-level model (round-robin choice, shadow memory, latency queue).
module tb_multicore_mem_sync;
  localparam int N  = 3;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam logic [AW-1:0] BAR = 16'd23;

  logic            clk = 1'b0;
  logic            reset, start;
  logic [N-1:0]    core_req, core_we, core_finish;
  logic [N*AW-1:0] core_addr;
  logic [N*DW-1:0] core_wdata;
  logic [N-1:0]    core_gnt, core_run, core_rvalid;
  logic [DW-1:0]   core_rdata, ram_wdata, ram_rdata;
  logic            ram_read, ram_write, finish_process;
  logic [AW-1:0]   ram_addr;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] mem [0:255];

  multicore_mem_sync #(.NUM_CORES(N), .ADDR_W(AW), .DATA_W(DW), .BARRIER_ADDR(BAR)) dut (
    .clk(clk), .reset(reset), .start(start),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_finish(core_finish),
    .core_gnt(core_gnt), .core_run(core_run), .core_rvalid(core_rvalid),
    .core_rdata(core_rdata), .ram_read(ram_read), .ram_write(ram_write),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .finish_process(finish_process)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] init_val(input int a);
    return DW'(a * 37 + 5);
  endfunction

  // Single-port synchronous RAM, preloaded with a known pattern while reset is high.
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
    end else begin
      if (ram_write) mem[ram_addr[7:0]] <= ram_wdata;
      if (ram_read)  ram_rdata <= mem[ram_addr[7:0]];
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  task automatic do_reset();
    reset = 1'b1; start = 1'b0;
    core_req = '0; core_we = '0; core_finish = '0;
    core_addr = '0; core_wdata = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic begin_run();
    do_reset();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0;
    core_req = '0; core_we = '0; core_finish = '0;
    core_addr = '0; core_wdata = '0;
    #1;
    n_tests++;
    if ({core_gnt, core_run, core_rvalid, core_rdata, ram_read, ram_write,
         ram_addr, ram_wdata, finish_process} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs gnt=%b run=%b rv=%b rd=%h rr=%b rw=%b a=%h wd=%h fp=%b exp all 0",
               core_gnt, core_run, core_rvalid, core_rdata, ram_read, ram_write,
               ram_addr, ram_wdata, finish_process);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    core_req = 3'b111;
    repeat (3) begin
      @(negedge clk); #1;
      n_tests++;
      if (core_gnt !== 3'b000 || core_run !== 3'b000) begin
        n_fail++;
        $display("FAIL idle_no_grant gnt=%b run=%b exp 000/000", core_gnt, core_run);
      end
    end
  endtask

  task automatic test_start();
    do_reset();
    core_req = 3'b111;
    start = 1'b1;
    #1;
    n_tests++;
    if (core_gnt !== 3'b000) begin
      n_fail++;
      $display("FAIL start_cycle_gnt got %b exp 000", core_gnt);
    end
    @(negedge clk);
    start = 1'b0;
    #1;
    n_tests++;
    if (core_run !== 3'b111) begin
      n_fail++;
      $display("FAIL start_run got %b exp 111", core_run);
    end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] exp_oh;
    int k;
    begin_run();
    for (int i = 0; i < N; i++) core_addr[i*AW +: AW] = AW'(10 + i);
    core_we  = '0;
    core_req = 3'b111;
    for (int c = 0; c < 7; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      exp_oh = N'(1) << (c % N);
      n_tests++;
      if (core_gnt !== exp_oh) begin
        n_fail++;
        $display("FAIL rr_gnt c=%0d got %b exp %b", c, core_gnt, exp_oh);
      end
      if (c >= 1) begin
        k = (c - 1) % N;
        n_tests++;
        if (ram_read !== 1'b1 || ram_write !== 1'b0 || ram_addr !== AW'(10 + k)) begin
          n_fail++;
          $display("FAIL rr_strobe c=%0d rd=%b wr=%b addr=%0d exp 1/0/%0d",
                   c, ram_read, ram_write, ram_addr, 10 + k);
        end
      end
      if (c >= 2) begin
        k = (c - 2) % N;
        exp_oh = N'(1) << k;
        n_tests++;
        if (core_rvalid !== exp_oh || core_rdata !== init_val(10 + k)) begin
          n_fail++;
          $display("FAIL rr_rvalid c=%0d rv=%b data=%h exp %b/%h",
                   c, core_rvalid, core_rdata, exp_oh, init_val(10 + k));
        end
      end
    end
    core_req = '0;
  endtask

  task automatic test_write_read();
    begin_run();
    core_addr[0 +: AW]  = 16'd5;
    core_wdata[0 +: DW] = 16'hBEEF;
    core_we  = 3'b001;
    core_req = 3'b001;
    #1;
    n_tests++;
    if (core_gnt !== 3'b001) begin
      n_fail++;
      $display("FAIL wr_gnt got %b exp 001", core_gnt);
    end
    @(negedge clk);
    core_we = 3'b000;
    #1;
    n_tests++;
    if (core_gnt !== 3'b001 || ram_write !== 1'b1 || ram_read !== 1'b0 ||
        ram_addr !== 16'd5 || ram_wdata !== 16'hBEEF) begin
      n_fail++;
      $display("FAIL wr_strobe gnt=%b wr=%b rd=%b addr=%h wd=%h exp 001/1/0/0005/beef",
               core_gnt, ram_write, ram_read, ram_addr, ram_wdata);
    end
    @(negedge clk);
    core_req = '0;
    #1;
    n_tests++;
    if (ram_read !== 1'b1 || ram_write !== 1'b0 || ram_addr !== 16'd5) begin
      n_fail++;
      $display("FAIL rd_strobe rd=%b wr=%b addr=%h exp 1/0/0005", ram_read, ram_write, ram_addr);
    end
    @(negedge clk); #1;
    n_tests++;
    if (core_rvalid !== 3'b001 || core_rdata !== 16'hBEEF) begin
      n_fail++;
      $display("FAIL rd_data rv=%b data=%h exp 001/beef", core_rvalid, core_rdata);
    end
  endtask

  task automatic test_barrier();
    begin_run();
    for (int i = 0; i < N; i++) core_addr[i*AW +: AW] = BAR;
    core_we  = '0;
    core_req = 3'b001;
    #1;
    n_tests++;
    if (core_gnt !== 3'b001) begin
      n_fail++;
      $display("FAIL bar_gnt0 got %b exp 001", core_gnt);
    end
    @(negedge clk);
    core_req = 3'b010;
    #1;
    n_tests++;
    if (core_gnt !== 3'b010 || core_run !== 3'b110) begin
      n_fail++;
      $display("FAIL bar_park0 gnt=%b run=%b exp 010/110", core_gnt, core_run);
    end
    @(negedge clk);
    core_req = 3'b100;
    #1;
    n_tests++;
    if (core_gnt !== 3'b100 || core_run !== 3'b100) begin
      n_fail++;
      $display("FAIL bar_park1 gnt=%b run=%b exp 100/100", core_gnt, core_run);
    end
    @(negedge clk);
    core_req = '0;
    #1;
    n_tests++;
    if (ram_read !== 1'b1 || ram_addr !== BAR || core_run !== 3'b000) begin
      n_fail++;
      $display("FAIL bar_last rd=%b addr=%0d run=%b exp 1/23/000", ram_read, ram_addr, core_run);
    end
    @(negedge clk); #1;
    n_tests++;
    if (core_run !== 3'b111 || core_rvalid !== 3'b100) begin
      n_fail++;
      $display("FAIL bar_release run=%b rv=%b exp 111/100", core_run, core_rvalid);
    end
  endtask

  task automatic test_finish_release();
    bit seen;
    begin_run();
    for (int i = 0; i < N; i++) core_addr[i*AW +: AW] = BAR;
    core_we  = '0;
    core_req = 3'b001;
    @(negedge clk);
    core_req = 3'b010;
    @(negedge clk);
    core_req    = '0;
    core_finish = 3'b100;
    #1;
    n_tests++;
    if (core_run !== 3'b100) begin
      n_fail++;
      $display("FAIL fin_parked run=%b exp 100", core_run);
    end
    @(negedge clk);
    core_finish = '0;
    #1;
    n_tests++;
    if (core_run !== 3'b000) begin
      n_fail++;
      $display("FAIL fin_core2_off run=%b exp 000", core_run);
    end
    @(negedge clk); #1;
    n_tests++;
    if (core_run !== 3'b011) begin
      n_fail++;
      $display("FAIL fin_release run=%b exp 011", core_run);
    end
    core_finish = 3'b011;
    @(negedge clk);
    core_finish = '0;
    core_req    = 3'b111;
    seen = 1'b0;
    for (int c = 0; c < 4 && !seen; c++) begin
      @(negedge clk); #1;
      if (finish_process === 1'b1) seen = 1'b1;
    end
    n_tests++;
    if (!seen || core_run !== 3'b000 || core_gnt !== 3'b000) begin
      n_fail++;
      $display("FAIL fin_process fp_seen=%0d run=%b gnt=%b exp 1/000/000", seen, core_run, core_gnt);
    end
    core_req = '0;
  endtask

  task automatic test_reset_mid();
    begin_run();
    core_addr[0 +: AW] = 16'd7;
    core_we  = '0;
    core_req = 3'b001;
    @(negedge clk);
    core_req = '0;
    #1;
    n_tests++;
    if (ram_read !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_pending rd=%b exp 1", ram_read);
    end
    reset = 1'b1;
    #1;
    n_tests++;
    if ({core_gnt, core_run, core_rvalid, core_rdata, ram_read, ram_write,
         ram_addr, ram_wdata, finish_process} !== '0) begin
      n_fail++;
      $display("FAIL mid_async run=%b rv=%b rd=%b wr=%b addr=%h fp=%b exp all 0",
               core_run, core_rvalid, ram_read, ram_write, ram_addr, finish_process);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      n_tests++;
      if (core_rvalid !== 3'b000) begin
        n_fail++;
        $display("FAIL mid_no_rvalid c=%0d rv=%b exp 000", c, core_rvalid);
      end
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    core_addr[1*AW +: AW] = 16'd8;
    core_req = 3'b010;
    #1;
    n_tests++;
    if (core_gnt !== 3'b010) begin
      n_fail++;
      $display("FAIL mid_restart_gnt got %b exp 010", core_gnt);
    end
    @(negedge clk);
    core_req = '0;
    @(negedge clk); #1;
    n_tests++;
    if (core_rvalid !== 3'b010 || core_rdata !== init_val(8)) begin
      n_fail++;
      $display("FAIL mid_restart_read rv=%b data=%h exp 010/%h", core_rvalid, core_rdata, init_val(8));
    end
  endtask

  task automatic test_random();
    logic [DW-1:0] shadow [0:255];
    logic [N-1:0]  pv, pwe;
    logic [AW-1:0] pa [N];
    logic [DW-1:0] pd [N];
    int            ptr, k, cand;
    bit            s1_v, s1_we;
    logic [AW-1:0] s1_addr;
    logic [DW-1:0] s1_wdata, s1_data, s2_data;
    logic [N-1:0]  s2_oh, exp_g;
    int            s1_k;

    for (int i = 0; i < 256; i++) shadow[i] = init_val(i);
    ptr = 0; s1_v = 0; s1_we = 0; s1_k = 0; s1_addr = '0; s1_wdata = '0; s1_data = '0;
    s2_oh = '0; s2_data = '0; pv = '0; pwe = '0;
    for (int i = 0; i < N; i++) begin pa[i] = '0; pd[i] = '0; end
    begin_run();
    for (int c = 0; c < 400; c++) begin
      if (c > 0) @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (!pv[i] && ($urandom_range(0, 1) == 1)) begin
          pv[i]  = 1'b1;
          pwe[i] = 1'($urandom_range(0, 1));
          pa[i]  = AW'($urandom_range(0, 63));
          if (pa[i] == BAR) pa[i] = 16'd24;
          pd[i]  = DW'($urandom);
        end
        core_addr[i*AW +: AW]  = pa[i];
        core_wdata[i*DW +: DW] = pd[i];
      end
      core_req = pv;
      core_we  = pwe;
      #1;
      k = -1;
      for (int off = 0; off < N; off++) begin
        cand = (ptr + off) % N;
        if (k < 0 && pv[cand]) k = cand;
      end
      exp_g = (k >= 0) ? (N'(1) << k) : '0;
      n_tests++;
      if (core_gnt !== exp_g) begin
        n_fail++;
        $display("FAIL rnd_gnt c=%0d got %b exp %b", c, core_gnt, exp_g);
      end
      n_tests++;
      if (ram_read !== (s1_v && !s1_we) || ram_write !== (s1_v && s1_we) ||
          (s1_v && ram_addr !== s1_addr) || (s1_v && s1_we && ram_wdata !== s1_wdata)) begin
        n_fail++;
        $display("FAIL rnd_strobe c=%0d rd=%b wr=%b addr=%h wd=%h exp v=%0d we=%0d addr=%h wd=%h",
                 c, ram_read, ram_write, ram_addr, ram_wdata, s1_v, s1_we, s1_addr, s1_wdata);
      end
      n_tests++;
      if (core_rvalid !== s2_oh || core_rdata !== ((s2_oh != 0) ? s2_data : '0)) begin
        n_fail++;
        $display("FAIL rnd_rvalid c=%0d rv=%b data=%h exp %b/%h", c, core_rvalid, core_rdata, s2_oh, s2_data);
      end
      s2_oh   = (s1_v && !s1_we) ? (N'(1) << s1_k) : '0;
      s2_data = s1_data;
      s1_v    = (k >= 0);
      if (k >= 0) begin
        s1_k     = k;
        s1_we    = pwe[k];
        s1_addr  = pa[k];
        s1_wdata = pd[k];
        s1_data  = shadow[pa[k][7:0]];
        if (pwe[k]) shadow[pa[k][7:0]] = pd[k];
        pv[k] = 1'b0;
        ptr   = (k + 1) % N;
      end
    end
    core_req = '0;
  endtask

  initial begin
    test_reset();
    test_start();
    test_round_robin();
    test_write_read();
    test_barrier();
    test_finish_release();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
